// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, receiver state encoding and a parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Parity bit a correct transmitter sends for the given payload (payload zero-extended).
  function automatic logic parity_bit(input logic [8:0] data, input parity_e par);
    logic x;
    x = ^data;
    case (par)
      PAR_EVEN: parity_bit = x;
      PAR_ODD:  parity_bit = ~x;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous serial lines; resets to the idle-high level.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // capture the asynchronous input through two stages, idling high in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// break detection and a single holding register with sticky overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter parity_e     PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_serial_i,
  input  logic                 rx_ready_i,
  output logic                 rx_dv_o,
  output logic [DATA_BITS-1:0] rx_byte_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_break_o,
  output logic                 rx_overrun_o,
  output logic                 rx_busy_o
);

  localparam int unsigned   TW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned   BW        = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  rx_state_e            state_r;
  logic [TW-1:0]        timer_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 zero_r;      // every bit sampled so far in this frame was low
  logic                 par_err_r;
  logic                 stop_err_r;  // an earlier stop bit of this frame was low
  logic                 dv_r;
  logic [DATA_BITS-1:0] byte_r;
  logic                 perr_out_r;
  logic                 ferr_out_r;
  logic                 brk_r;
  logic                 ovr_r;
  logic                 busy_r;

  logic line_s;
  logic tick_s;
  logic accept_s;

  uart_sync2 u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_serial_i),
    .q_o    (line_s)
  );

  // sample point: half a bit into the start bit, a full bit after every later sample
  always_comb begin
    tick_s = 1'b0;
    if (state_r == RX_START) begin
      tick_s = (timer_r == T_HALF);
    end else begin
      tick_s = (timer_r == T_FULL);
    end
  end

  assign accept_s = dv_r & rx_ready_i;

  // receive FSM together with the holding register and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= RX_IDLE;
      timer_r    <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      zero_r     <= 1'b0;
      par_err_r  <= 1'b0;
      stop_err_r <= 1'b0;
      dv_r       <= 1'b0;
      byte_r     <= '0;
      perr_out_r <= 1'b0;
      ferr_out_r <= 1'b0;
      brk_r      <= 1'b0;
      ovr_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      brk_r <= 1'b0;
      if (accept_s) begin
        dv_r <= 1'b0;
      end
      case (state_r)
        RX_IDLE: begin
          timer_r   <= '0;
          bit_cnt_r <= '0;
          if (!line_s) begin
            state_r <= RX_START;
            busy_r  <= 1'b1;
          end
        end
        RX_START: begin
          if (tick_s) begin
            timer_r <= '0;
            if (!line_s) begin
              state_r    <= RX_DATA;
              zero_r     <= 1'b1;
              par_err_r  <= 1'b0;
              stop_err_r <= 1'b0;
            end else begin
              state_r <= RX_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_s) begin
            timer_r <= '0;
            shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
            zero_r  <= zero_r & ~line_s;
            if (bit_cnt_r == LAST_DATA) begin
              bit_cnt_r <= '0;
              if (HAS_PAR) begin
                state_r <= RX_PARITY;
              end else begin
                state_r <= RX_STOP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_PARITY: begin
          if (tick_s) begin
            timer_r   <= '0;
            par_err_r <= (line_s != parity_bit(9'(shift_r), PARITY));
            zero_r    <= zero_r & ~line_s;
            state_r   <= RX_STOP;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_s) begin
            timer_r <= '0;
            if ((bit_cnt_r == '0) && zero_r && !line_s) begin
              brk_r     <= 1'b1;
              bit_cnt_r <= '0;
              state_r   <= RX_BREAK_WAIT;
            end else if (bit_cnt_r == LAST_STOP) begin
              // leave mid-bit so a start edge in the next half bit is not missed
              bit_cnt_r <= '0;
              state_r   <= RX_IDLE;
              busy_r    <= 1'b0;
              if (!dv_r || rx_ready_i) begin
                dv_r       <= 1'b1;
                byte_r     <= shift_r;
                perr_out_r <= par_err_r;
                ferr_out_r <= stop_err_r | ~line_s;
              end else begin
                ovr_r <= 1'b1;
              end
            end else begin
              stop_err_r <= stop_err_r | ~line_s;
              bit_cnt_r  <= bit_cnt_r + 1'b1;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_BREAK_WAIT: begin
          if (line_s) begin
            state_r <= RX_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= RX_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_dv_o         = dv_r;
  assign rx_byte_o       = byte_r;
  assign rx_parity_err_o = perr_out_r;
  assign rx_frame_err_o  = ferr_out_r;
  assign rx_break_o      = brk_r;
  assign rx_overrun_o    = ovr_r;
  assign rx_busy_o       = busy_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations, randomized frames,
// directed glitch / break / overrun / reset-abort scenarios.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line  = 3'b111;
  logic [2:0] rdy   = 3'b000;
  logic [2:0] dv, pe, fe, brk, ovr, busy;
  logic [7:0] byte0, byte1;
  logic [6:0] byte2;
  logic [8:0] byte_w [3];

  int cfg_cpb  [3] = '{217, 16, 8};
  int cfg_bits [3] = '{8, 8, 7};
  int cfg_par  [3] = '{0, 1, 2};
  int cfg_stop [3] = '{1, 2, 1};

  exp_t sb_q [3][$];
  int brk_seen  [3];
  int brk_exp   [3];
  int dv_cycles [3];
  int mode      [3];   // 0: ready high, 1: random ready delay, 2: ready low
  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  assign byte_w[0] = {1'b0, byte0};
  assign byte_w[1] = {1'b0, byte1};
  assign byte_w[2] = {2'b00, byte2};

  uart_rx_cfg #(.CLKS_PER_BIT(217)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(line[0]), .rx_ready_i(rdy[0]),
    .rx_dv_o(dv[0]), .rx_byte_o(byte0), .rx_parity_err_o(pe[0]), .rx_frame_err_o(fe[0]),
    .rx_break_o(brk[0]), .rx_overrun_o(ovr[0]), .rx_busy_o(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(16), .PARITY(PAR_EVEN), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(line[1]), .rx_ready_i(rdy[1]),
    .rx_dv_o(dv[1]), .rx_byte_o(byte1), .rx_parity_err_o(pe[1]), .rx_frame_err_o(fe[1]),
    .rx_break_o(brk[1]), .rx_overrun_o(ovr[1]), .rx_busy_o(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(PAR_ODD)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(line[2]), .rx_ready_i(rdy[2]),
    .rx_dv_o(dv[2]), .rx_byte_o(byte2), .rx_parity_err_o(pe[2]), .rx_frame_err_o(fe[2]),
    .rx_break_o(brk[2]), .rx_overrun_o(ovr[2]), .rx_busy_o(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a frame means, counted from the bits on the wire.
  function automatic void model(input int i, input logic [8:0] data, input logic pbit,
                                input logic [1:0] stops, output exp_t e, output bit is_break);
    int ones;
    ones = 0;
    for (int b = 0; b < cfg_bits[i]; b++) ones += int'(data[b]);
    e.data = 9'(int'(data) % (1 << cfg_bits[i]));
    e.pe   = 1'b0;
    if (cfg_par[i] == 1) e.pe = (pbit != (ones % 2 == 1));
    else if (cfg_par[i] == 2) e.pe = (pbit != (ones % 2 == 0));
    e.fe = (stops[0] == 1'b0) || (cfg_stop[i] == 2 && stops[1] == 1'b0);
    is_break = (ones == 0) && (cfg_par[i] == 0 || pbit == 1'b0) && (stops[0] == 1'b0);
  endfunction

  task automatic drive_bit(input int i, input logic v);
    line[i] = v;
    repeat (cfg_cpb[i]) @(negedge clk);
  endtask

  task automatic issue(input int i, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops, input bit deliver);
    exp_t e;
    bit   is_brk;
    model(i, data, pbit, stops, e, is_brk);
    if (is_brk) brk_exp[i]++;
    else if (deliver) sb_q[i].push_back(e);
    drive_bit(i, 1'b0);
    for (int b = 0; b < cfg_bits[i]; b++) drive_bit(i, data[b]);
    if (cfg_par[i] != 0) drive_bit(i, pbit);
    for (int s = 0; s < cfg_stop[i]; s++) drive_bit(i, stops[s]);
    line[i] = 1'b1;
  endtask

  task automatic rand_frame(input int i);
    logic [8:0] d;
    logic       p;
    d = 9'($urandom_range(0, (1 << cfg_bits[i]) - 1));
    p = 1'($urandom_range(0, 1));
    issue(i, d, p, 2'b11, 1'b1);
    repeat ($urandom_range(0, 2) * cfg_cpb[i]) @(negedge clk);
  endtask

  task automatic drain(input int i, input int budget);
    int c;
    c = 0;
    while (sb_q[i].size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("drain_dut%0d", i), sb_q[i].size(), 0);
    repeat (30) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever a new byte appears and drives rx_ready_i.
  initial begin : mon
    logic [2:0] prev_dv;
    logic [2:0] prev_acc;
    bit         held_ok [3];
    exp_t       held    [3];
    int         wait_cnt[3];
    exp_t       e;
    prev_dv  = 3'b000;
    prev_acc = 3'b000;
    for (int i = 0; i < 3; i++) begin
      held_ok[i]  = 1'b0;
      wait_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (brk[i]) brk_seen[i]++;
        if (dv[i]) dv_cycles[i]++;
        if (rst_n && dv[i] && (!prev_dv[i] || prev_acc[i])) begin
          if (sb_q[i].size() == 0) begin
            total++;
            bad++;
            held_ok[i] = 1'b0;
            $display("FAIL unexpected_byte_dut%0d: got 0x%0h expected none", i, byte_w[i]);
          end else begin
            e = sb_q[i].pop_front();
            check($sformatf("byte_dut%0d", i), {21'd0, pe[i], fe[i], byte_w[i]},
                  {21'd0, e.pe, e.fe, e.data});
            held[i]    = e;
            held_ok[i] = 1'b1;
          end
          wait_cnt[i] = $urandom_range(0, 10);
        end else if (rst_n && dv[i] && held_ok[i]) begin
          check($sformatf("hold_dut%0d", i), {21'd0, pe[i], fe[i], byte_w[i]},
                {21'd0, held[i].pe, held[i].fe, held[i].data});
        end
        case (mode[i])
          0: rdy[i] = 1'b1;
          1: begin
            if (dv[i] && wait_cnt[i] == 0) begin
              rdy[i] = 1'b1;
            end else begin
              rdy[i] = 1'b0;
              if (wait_cnt[i] > 0) wait_cnt[i]--;
            end
          end
          default: rdy[i] = 1'b0;
        endcase
        prev_dv[i]  = rst_n & dv[i];
        prev_acc[i] = rst_n & dv[i] & rdy[i];
      end
    end
  end

  initial begin : watchdog
    #(40 * 100000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int b0;
    rst_n = 1'b0;
    line  = 3'b111;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outs_dut%0d", i),
            {17'd0, dv[i], pe[i], fe[i], brk[i], ovr[i], busy[i], byte_w[i]}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single frame, ready held high: one-cycle dv
    mode[0] = 0;
    b0 = dv_cycles[0];
    issue(0, 9'h0AB, 1'b0, 2'b11, 1'b1);
    drain(0, 50);
    check("dv_one_cycle", dv_cycles[0] - b0, 1);

    // 50-cycle low glitch is rejected at the half-bit start sample
    line[0] = 1'b0;
    repeat (50) @(negedge clk);
    line[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_busy_mid", busy[0], 1);
    repeat (55) @(negedge clk);
    check("glitch_busy_end", busy[0], 0);

    // line low for 12 bit periods: one break pulse, busy until the line recovers
    b0 = brk_seen[0];
    brk_exp[0]++;
    line[0] = 1'b0;
    repeat (12 * 217) @(negedge clk);
    check("break_busy_low", busy[0], 1);
    check("break_pulse", brk_seen[0] - b0, 1);
    line[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_idle", busy[0], 0);

    // random frames with random consumer delay
    mode[0] = 1;
    for (int k = 0; k < 4; k++) rand_frame(0);
    drain(0, 50);

    // even parity, two stop bits
    mode[1] = 1;
    issue(1, 9'h007, 1'b0, 2'b11, 1'b1);
    issue(1, 9'h007, 1'b1, 2'b11, 1'b1);
    issue(1, 9'h05A, 1'b0, 2'b01, 1'b1);
    repeat (32) @(negedge clk);
    issue(1, 9'h000, 1'b0, 2'b00, 1'b1);
    repeat (48) @(negedge clk);
    for (int k = 0; k < 8; k++) rand_frame(1);
    drain(1, 50);

    // odd parity, 7 data bits
    mode[2] = 1;
    for (int k = 0; k < 10; k++) rand_frame(2);
    drain(2, 50);

    // overrun: consumer stalled across two frames
    mode[0] = 2;
    check("ovr_clear_before", ovr[0], 0);
    issue(0, 9'h011, 1'b0, 2'b11, 1'b1);
    issue(0, 9'h022, 1'b0, 2'b11, 1'b0);
    repeat (3) @(negedge clk);
    check("ovr_set", ovr[0], 1);
    check("ovr_dv_held", dv[0], 1);
    check("ovr_byte_kept", byte0, 8'h11);
    mode[0] = 0;
    repeat (3) @(negedge clk);
    check("ovr_dv_cleared", dv[0], 0);
    check("ovr_sticky", ovr[0], 1);
    drain(0, 10);

    // reset in the middle of a data bit aborts the frame
    line[1] = 1'b0;
    repeat (16) @(negedge clk);
    line[1] = 1'b1;
    repeat (16) @(negedge clk);
    line[1] = 1'b0;
    repeat (16) @(negedge clk);
    line[1] = 1'b1;
    repeat (8) @(negedge clk);
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_dut1", busy[1], 0);
    check("rst_dv_dut1", dv[1], 0);
    check("rst_ovr_dut0", ovr[0], 0);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    issue(1, 9'h03C, 1'b0, 2'b11, 1'b1);
    drain(1, 50);

    for (int i = 0; i < 3; i++) check($sformatf("break_count_dut%0d", i), brk_seen[i], brk_exp[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default PAR_NONE, one of PAR_NONE / PAR_EVEN / PAR_ODD.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 and 2.
REQ-005 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_serial_i, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_ready_i, input, 1, consumer accepts the held byte.
REQ-009 SHALL have port rx_dv_o, output, 1, held byte valid.
REQ-010 SHALL have port rx_byte_o, output, DATA_BITS, received payload, LSB received first.
REQ-011 SHALL have port rx_parity_err_o, output, 1, parity mismatch on the held byte.
REQ-012 SHALL have port rx_frame_err_o, output, 1, a stop bit sampled low on the held byte.
REQ-013 SHALL have port rx_break_o, output, 1, one-cycle pulse on break detection.
REQ-014 SHALL have port rx_overrun_o, output, 1, sticky; a frame was dropped because the holding register was full.
REQ-015 SHALL have port rx_busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx_serial_i through a 2-flop synchronizer before any use; added latency is 2 cycles.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-018 IDLE SHALL go to START on a synchronized low and clear the bit-timer.
REQ-019 START SHALL sample at timer = CLKS_PER_BIT/2 (integer division), going to DATA if low and back to IDLE if high (glitch reject, no outputs).
REQ-020 DATA, PARITY and STOP SHALL each sample once per bit, CLKS_PER_BIT cycles after the previous sample, with the timer reset to 0 at each sample.
REQ-021 DATA SHALL shift DATA_BITS samples LSB-first, then go to PARITY if PARITY != PAR_NONE, else to STOP.
REQ-022 Parity error SHALL be flagged when the received parity bit does not equal XOR(data) for PAR_EVEN, or ~XOR(data) for PAR_ODD.
REQ-023 STOP SHALL sample STOP_BITS bits, and any low sample SHALL set the frame error.
REQ-024 After the last stop sample the FSM SHALL return to IDLE immediately (mid-bit), so that a start edge in the next half bit is caught.
REQ-025 Break SHALL be declared when all data bits, the parity bit (if present) and the first stop bit are all 0.
REQ-026 On break: rx_break_o pulses 1 cycle, no byte is delivered, and the FSM goes to BREAK_WAIT until the synchronized line is high, then to IDLE.
REQ-027 On frame completion with rx_dv_o = 0 (or rx_dv_o = 1 and rx_ready_i = 1 in the same cycle), the next cycle SHALL load rx_byte_o and both error flags and set rx_dv_o.
REQ-028 rx_dv_o, rx_byte_o and the error flags SHALL hold stable until the cycle after rx_dv_o && rx_ready_i; rx_dv_o then clears unless a reload per REQ-027 occurs in the same cycle.
REQ-029 On frame completion with rx_dv_o = 1 and rx_ready_i = 0, the frame SHALL be discarded and rx_overrun_o set; rx_overrun_o clears only on reset.
REQ-030 The bit-timer SHALL be sized to $clog2(CLKS_PER_BIT) bits and the bit counter to $clog2(DATA_BITS+1) bits, with no wrap inside a frame.

Reset
REQ-031 While rst_ni = 0: FSM in IDLE, synchronizer flops at 1, timers and counters at 0, all outputs at 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no delivery; after release, reception resumes from IDLE.

Structure
REQ-033 The shared package uart_pkg SHALL hold the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_state_e enum.
REQ-034 The synchronizer SHALL be a separate sub-module uart_sync2, reset to 1, reusable by the TX and other blocks; all other logic stays in uart_rx_cfg.

Verification
Test setup: CLKS_PER_BIT = 217, 40 ns clock, 8680 ns bits.
REQ-035 Default parameters, send 0xAB with rx_ready_i = 1 -> rx_dv_o for exactly 1 cycle, rx_byte_o = 0xAB, no error flags.
REQ-036 PARITY = PAR_EVEN, send 0x07 with parity bit 0 -> byte 0x07 delivered with rx_parity_err_o = 1; with parity bit 1 -> rx_parity_err_o = 0.
REQ-037 rx_ready_i = 0, send 0x11 then 0x22 -> rx_byte_o stays 0x11 and rx_overrun_o = 1; after raising rx_ready_i, rx_dv_o clears.
REQ-038 Hold the line low for 12 bit periods -> rx_break_o pulses once, no rx_dv_o, rx_busy_o stays high until the line returns high.
REQ-039 Low glitch of 50 cycles, then idle -> no rx_dv_o and rx_busy_o back to 0 by cycle 111.
REQ-040 STOP_BITS = 2, second stop bit driven low on 0x5A -> rx_byte_o = 0x5A with rx_frame_err_o = 1; separately, rst_ni pulse mid-data bit -> no delivery and the next frame 0x3C is received correctly.
